// File: rtl/axil_led_bank_pkg.sv
// led_bank_pkg: shared constants and types for the axil_led_bank slave.
//   - register word indices (address bits [4:2])
//   - AXI response codes
//   - write/read FSM state enums
//   - INFO register field positions
package led_bank_pkg;

   localparam logic [2:0] REG_LED_DATA  = 3'd0;
   localparam logic [2:0] REG_LED_SET   = 3'd1;
   localparam logic [2:0] REG_LED_CLR   = 3'd2;
   localparam logic [2:0] REG_BLINK_EN  = 3'd3;
   localparam logic [2:0] REG_BLINK_DIV = 3'd4;
   localparam logic [2:0] REG_INFO      = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int INFO_PHASE_BIT = 31;
   localparam int INFO_DIV_LSB   = 8;
   localparam int INFO_NUM_LSB   = 0;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_led_bank_if.sv
// axil_led_bank_if: AXI4-Lite bus bundle for the LED bank slave.
//   ADDR_W / DATA_W : address and data widths
//   slave modport   : seen from the LED bank
//   master modport  : seen from the interconnect / testbench
interface axil_led_bank_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input  bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input  rready
   );

   modport master (
      output awaddr, awprot, awvalid, input  awready,
      output wdata, wstrb, wvalid,    input  wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input  arready,
      input  rdata, rresp, rvalid,    output rready
   );
endinterface

// File: rtl/axil_led_bank_prescaler.sv
// led_blink_prescaler: free-running blink divider.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_div          : terminal count; phase period is 2*(i_div+1) cycles
//   i_div_load     : restart the count from 0 (phase kept)
//   i_en           : count enable
//   o_phase        : blink phase, toggles each time the count wraps
module led_blink_prescaler #(
   parameter int DIV_WIDTH = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DIV_WIDTH-1:0] i_div,
   input  logic                 i_div_load,
   input  logic                 i_en,
   output logic                 o_phase
);
   logic [DIV_WIDTH-1:0] r_cnt;
   logic                 r_phase;

   // Wrap is by equality only; a divisor change always restarts the count,
   // so r_cnt can never sit above i_div and overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (i_div_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == i_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
         end
      end
   end

   assign o_phase = r_phase;
endmodule

// File: rtl/axil_led_bank.sv
// axil_led_bank: AXI4-Lite slave driving NUM_LEDS outputs.
//   s_axi_aclk, s_axi_aresetn : clock, async active-low reset
//   s_axi                     : AXI4-Lite slave bus (axil_led_bank_if.slave)
//   led_out                   : registered LED drive
// Registers (addr[4:2]): LED_DATA, LED_SET, LED_CLR, BLINK_EN, BLINK_DIV,
// INFO; the two remaining words answer SLVERR.
module axil_led_bank
   import led_bank_pkg::*;
#(
   parameter int                  AXI_ADDR_WIDTH = 32,
   parameter int                  AXI_DATA_WIDTH = 32,
   parameter int                  NUM_LEDS       = 4,
   parameter int                  DIV_WIDTH      = 24,
   parameter logic [NUM_LEDS-1:0] LED_RESET      = '0
) (
   input  logic                s_axi_aclk,
   input  logic                s_axi_aresetn,
   axil_led_bank_if.slave      s_axi,
   output logic [NUM_LEDS-1:0] led_out
);
   localparam int SW = AXI_DATA_WIDTH / 8;

   logic                      r_rst_done;
   wr_state_t                 r_wr_state, w_wr_next;
   rd_state_t                 r_rd_state, w_rd_next;
   logic                      r_aw_held, r_w_held;
   logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;
   logic [SW-1:0]             r_wstrb;
   logic [1:0]                r_bresp;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                r_rresp;
   logic [NUM_LEDS-1:0]       r_led, r_blink_en, r_led_out;
   logic [DIV_WIDTH-1:0]      r_div;

   logic                      w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
   logic                      w_any_strb, w_div_load, w_phase;
   logic [AXI_ADDR_WIDTH-1:0] w_awaddr;
   logic [AXI_DATA_WIDTH-1:0] w_wdata, w_mask, w_wbits, w_rd_val;
   logic [SW-1:0]             w_wstrb;
   logic [2:0]                w_idx;
   logic [1:0]                w_rd_resp;
   logic                      w_unused;

   // Holds the readies low until the first edge after reset release.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_rst_done <= 1'b0;
      else                r_rst_done <= 1'b1;
   end

   assign w_aw_hs = s_axi.awvalid & s_axi.awready;
   assign w_w_hs  = s_axi.wvalid  & s_axi.wready;
   assign w_ar_hs = s_axi.arvalid & s_axi.arready;

   // Each channel comes either from its holding register or straight off the
   // bus when it handshakes on the commit edge.
   assign w_awaddr   = r_aw_held ? r_awaddr : s_axi.awaddr;
   assign w_wdata    = r_w_held  ? r_wdata  : s_axi.wdata;
   assign w_wstrb    = r_w_held  ? r_wstrb  : s_axi.wstrb;
   assign w_idx      = w_awaddr[4:2];
   assign w_commit   = (r_wr_state == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
   assign w_wr_ok    = (w_idx <= REG_BLINK_DIV);
   assign w_any_strb = |w_wstrb;
   assign w_div_load = w_commit & w_any_strb & (w_idx == REG_BLINK_DIV);

   always_comb begin
      w_mask = '0;
      for (int k = 0; k < SW; k++) w_mask[8*k +: 8] = {8{w_wstrb[k]}};
   end
   assign w_wbits = w_wdata & w_mask;

   // ---------------- write FSM ----------------
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_wr_state <= W_IDLE;
      else                r_wr_state <= w_wr_next;
   end

   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (w_commit)     w_wr_next = W_RESP;
         W_RESP:  if (s_axi.bready) w_wr_next = W_IDLE;
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      s_axi.awready = 1'b0;
      s_axi.wready  = 1'b0;
      s_axi.bvalid  = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            s_axi.awready = r_rst_done & ~r_aw_held;
            s_axi.wready  = r_rst_done & ~r_w_held;
         end
         W_RESP:  s_axi.bvalid = 1'b1;
         default: ;
      endcase
   end
   assign s_axi.bresp = r_bresp;

   // Channel holding registers; flags are only cleared by the B handshake.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (r_wr_state == W_RESP && s_axi.bready) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end else begin
            if (w_aw_hs) begin
               r_aw_held <= 1'b1;
               r_awaddr  <= s_axi.awaddr;
            end
            if (w_w_hs) begin
               r_w_held <= 1'b1;
               r_wdata  <= s_axi.wdata;
               r_wstrb  <= s_axi.wstrb;
            end
         end
         if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // ---------------- register file ----------------
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_led      <= LED_RESET;
         r_blink_en <= '0;
         r_div      <= '1;
      end else if (w_commit && w_any_strb) begin
         case (w_idx)
            REG_LED_DATA:  r_led      <= (r_led & ~w_mask[NUM_LEDS-1:0]) | w_wbits[NUM_LEDS-1:0];
            REG_LED_SET:   r_led      <= r_led | w_wbits[NUM_LEDS-1:0];
            REG_LED_CLR:   r_led      <= r_led & ~w_wbits[NUM_LEDS-1:0];
            REG_BLINK_EN:  r_blink_en <= (r_blink_en & ~w_mask[NUM_LEDS-1:0]) | w_wbits[NUM_LEDS-1:0];
            REG_BLINK_DIV: r_div      <= (r_div & ~w_mask[DIV_WIDTH-1:0]) | w_wbits[DIV_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_rd_state <= R_IDLE;
      else                r_rd_state <= w_rd_next;
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_ar_hs)      w_rd_next = R_DATA;
         R_DATA:  if (s_axi.rready) w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi.arready = 1'b0;
      s_axi.rvalid  = 1'b0;
      case (r_rd_state)
         R_IDLE:  s_axi.arready = r_rst_done;
         R_DATA:  s_axi.rvalid  = 1'b1;
         default: ;
      endcase
   end
   assign s_axi.rdata = r_rdata;
   assign s_axi.rresp = r_rresp;

   // Decoded from pre-edge state, so a same-edge write is not visible.
   always_comb begin
      w_rd_val  = '0;
      w_rd_resp = RESP_OKAY;
      case (s_axi.araddr[4:2])
         REG_LED_DATA:              w_rd_val[NUM_LEDS-1:0]  = r_led;
         REG_LED_SET, REG_LED_CLR:  ;
         REG_BLINK_EN:              w_rd_val[NUM_LEDS-1:0]  = r_blink_en;
         REG_BLINK_DIV:             w_rd_val[DIV_WIDTH-1:0] = r_div;
         REG_INFO: begin
            w_rd_val[INFO_PHASE_BIT]      = w_phase;
            w_rd_val[INFO_DIV_LSB +: 8]   = 8'(DIV_WIDTH);
            w_rd_val[INFO_NUM_LSB +: 8]   = 8'(NUM_LEDS);
         end
         default:                   w_rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_val;
         r_rresp <= w_rd_resp;
      end
   end

   // ---------------- blink + LED drive ----------------
   led_blink_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
      .i_clk      (s_axi_aclk),
      .i_rst_n    (s_axi_aresetn),
      .i_div      (r_div),
      .i_div_load (w_div_load),
      .i_en       (1'b1),
      .o_phase    (w_phase)
   );

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) r_led_out <= '0;
      else                r_led_out <= r_led & (~r_blink_en | {NUM_LEDS{w_phase}});
   end
   assign led_out = r_led_out;

   // Protection bits and undecoded address/data bits are deliberately ignored.
   assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr, w_awaddr, w_wbits};
endmodule

// File: tb/tb_axil_led_bank.sv
module tb_axil_led_bank;
   import led_bank_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] led;
   always #5 clk = ~clk;

   axil_led_bank_if #(.ADDR_W(32), .DATA_W(32)) bus();

   axil_led_bank #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_LEDS(4),
      .DIV_WIDTH(24), .LED_RESET(4'h0)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rstn),
      .s_axi         (bus),
      .led_out       (led)
   );

   int          total = 0;
   int          bad   = 0;
   logic [1:0]  bq[$];     // expected write responses
   logic [33:0] rq[$];     // expected {rresp, rdata}
   logic [3:0]  m_led, m_en;
   logic [23:0] m_div;

   // ---------------- reference model ----------------
   function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m, b;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      b = d & m;
      case (a[4:2])
         3'd0: m_led = (m_led & ~m[3:0]) | b[3:0];
         3'd1: m_led = m_led | b[3:0];
         3'd2: m_led = m_led & ~b[3:0];
         3'd3: m_en  = (m_en & ~m[3:0]) | b[3:0];
         3'd4: m_div = (m_div & ~m[23:0]) | b[23:0];
         default: return RESP_SLVERR;
      endcase
      return RESP_OKAY;
   endfunction

   function automatic logic [33:0] mdl_read(input logic [31:0] a);
      case (a[4:2])
         3'd0:    return {RESP_OKAY, 28'h0, m_led};
         3'd3:    return {RESP_OKAY, 28'h0, m_en};
         3'd4:    return {RESP_OKAY, 8'h0, m_div};
         3'd5:    return {RESP_OKAY, 32'h0000_1804};  // phase assumed 0
         3'd6, 3'd7: return {RESP_SLVERR, 32'h0};
         default: return {RESP_OKAY, 32'h0};
      endcase
   endfunction

   task automatic mdl_reset;
      m_led = 4'h0; m_en = 4'h0; m_div = 24'hFF_FFFF;
   endtask

   // ---------------- bus drivers (no checking; X on timeout) ----------------
   // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int skew, output logic [1:0] resp, output int lat);
      bit aw_done, w_done, aw_go, w_go;
      int n;
      aw_done = 0; w_done = 0; n = 0; lat = -1; resp = 'x;
      @(negedge clk);
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = (skew >= 0);
      bus.wvalid  = (skew <= 0);
      while (!(aw_done && w_done) && n < 50) begin
         aw_go = bus.awvalid && bus.awready;
         w_go  = bus.wvalid && bus.wready;
         @(negedge clk); n++;
         if (aw_go) begin bus.awvalid = 0; aw_done = 1; end
         if (w_go)  begin bus.wvalid  = 0; w_done  = 1; end
         if (skew > 0 && n == skew)  bus.wvalid  = 1;
         if (skew < 0 && n == -skew) bus.awvalid = 1;
      end
      bus.awvalid = 0; bus.wvalid = 0;
      n = 0;
      while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
      if (bus.bvalid) begin
         lat = n; resp = bus.bresp;
         bus.bready = 1; @(negedge clk); bus.bready = 0;
      end
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [33:0] got);
      int n;
      n = 0; got = 'x;
      @(negedge clk);
      bus.araddr = addr; bus.arvalid = 1;
      while (!bus.arready && n < 50) begin @(negedge clk); n++; end
      if (bus.arready) begin
         @(negedge clk); bus.arvalid = 0;
         n = 0;
         while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
         if (bus.rvalid) begin
            got = {bus.rresp, bus.rdata};
            bus.rready = 1; @(negedge clk); bus.rready = 0;
         end
      end
      bus.arvalid = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      logic [33:0] g, x;
      repeat (3) @(negedge clk);
      total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin bad++;
         $display("FAIL reset_readies got=%b want=000", {bus.awready, bus.wready, bus.arready}); end
      total++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0 || bus.rdata !== 32'h0) begin bad++;
         $display("FAIL reset_outputs got=%b/%h want=0", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, bus.rdata); end
      total++; if (led !== 4'h0) begin bad++; $display("FAIL reset_led got=%h want=0", led); end
      rstn = 1'b1;
      @(negedge clk);
      total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin bad++;
         $display("FAIL release_readies got=%b want=111", {bus.awready, bus.wready, bus.arready}); end
      rq.push_back(34'({RESP_OKAY, 32'h0000_1804}));
      do_read(32'h14, g); x = rq.pop_front();
      total++; if (g !== x) begin bad++; $display("FAIL info_read got=%h want=%h", g, x); end
      total++; if (led !== 4'h0) begin bad++; $display("FAIL reset_led2 got=%h want=0", led); end
   endtask

   task automatic test_write_order;
      logic [1:0] r, e; int lat; logic [33:0] g, x;
      bq.push_back(mdl_write(32'h0, 32'h5, 4'hF));
      do_write(32'h0, 32'h5, 4'hF, 3, r, lat); e = bq.pop_front();
      total++; if (r !== e || lat !== 0) begin bad++; $display("FAIL aw_first resp=%b lat=%0d want=%b/0", r, lat, e); end
      total++; if (led !== 4'h5) begin bad++; $display("FAIL aw_first_led got=%h want=5", led); end
      bq.push_back(mdl_write(32'h0, 32'hA, 4'hF));
      do_write(32'h0, 32'hA, 4'hF, -3, r, lat); e = bq.pop_front();
      total++; if (r !== e || lat !== 0) begin bad++; $display("FAIL w_first resp=%b lat=%0d want=%b/0", r, lat, e); end
      total++; if (led !== 4'hA) begin bad++; $display("FAIL w_first_led got=%h want=a", led); end
      rq.push_back(mdl_read(32'h0));
      do_read(32'h0, g); x = rq.pop_front();
      total++; if (g !== x) begin bad++; $display("FAIL w_first_read got=%h want=%h", g, x); end
   endtask

   task automatic test_set_clr;
      logic [1:0] r, e; int lat; logic [33:0] g, x;
      logic [31:0] wa[6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h10, 32'h10};
      logic [31:0] wd[6] = '{32'h5, 32'h2, 32'h1, 32'hF, 32'h0, 32'hFFFF_FFFF};
      logic [3:0]  ws[6] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h2};
      logic [31:0] ra[6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h10};
      for (int i = 0; i < 6; i++) begin
         bq.push_back(mdl_write(wa[i], wd[i], ws[i]));
         do_write(wa[i], wd[i], ws[i], 0, r, lat); e = bq.pop_front();
         total++; if (r !== e) begin bad++; $display("FAIL setclr_bresp[%0d] got=%b want=%b", i, r, e); end
         rq.push_back(mdl_read(ra[i]));
         do_read(ra[i], g); x = rq.pop_front();
         total++; if (g !== x) begin bad++; $display("FAIL setclr_read[%0d] got=%h want=%h", i, g, x); end
      end
      rq.push_back(34'({RESP_OKAY, 32'h0}));
      do_read(32'h4, g); x = rq.pop_front();
      total++; if (g !== x) begin bad++; $display("FAIL set_reads_zero got=%h want=%h", g, x); end
   endtask

   task automatic test_blink;
      logic [1:0] r, e; int lat, last, toggles; logic [3:0] prev;
      logic [31:0] wa[3] = '{32'h10, 32'h0C, 32'h0};
      logic [31:0] wd[3] = '{32'h3, 32'h1, 32'h3};
      for (int i = 0; i < 3; i++) begin
         bq.push_back(mdl_write(wa[i], wd[i], 4'hF));
         do_write(wa[i], wd[i], 4'hF, 0, r, lat); e = bq.pop_front();
         total++; if (r !== e) begin bad++; $display("FAIL blink_setup[%0d] got=%b want=%b", i, r, e); end
      end
      prev = led; last = -1; toggles = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL blink_led1 cyc=%0d got=%b want=1", c, led[1]); end
         if (led[0] !== prev[0]) begin
            if (last >= 0) begin
               total++; if (c - last !== 4) begin bad++; $display("FAIL blink_half_period got=%0d want=4", c - last); end
            end
            last = c; toggles++;
         end
         prev = led;
      end
      total++; if (toggles < 9) begin bad++; $display("FAIL blink_toggles got=%0d want>=9", toggles); end
      // divisor 0: phase flips every cycle
      bq.push_back(mdl_write(32'h10, 32'h0, 4'hF));
      do_write(32'h10, 32'h0, 4'hF, 0, r, lat); e = bq.pop_front();
      total++; if (r !== e) begin bad++; $display("FAIL div0_bresp got=%b want=%b", r, e); end
      prev = led;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++; if (led[0] === prev[0]) begin bad++; $display("FAIL div0_toggle cyc=%0d got=%b want=%b", c, led[0], ~prev[0]); end
         prev = led;
      end
      bq.push_back(mdl_write(32'h0C, 32'h0, 4'hF));
      do_write(32'h0C, 32'h0, 4'hF, 0, r, lat); e = bq.pop_front();
      total++; if (r !== e) begin bad++; $display("FAIL blink_off got=%b want=%b", r, e); end
   endtask

   task automatic test_errors;
      logic [1:0] r, e; int lat; logic [33:0] g, x;
      logic [31:0] wa[2] = '{32'h14, 32'h1C};
      logic [31:0] ra[5] = '{32'h18, 32'h1C, 32'h20, 32'h0C, 32'h10};
      for (int i = 0; i < 2; i++) begin
         bq.push_back(mdl_write(wa[i], 32'hFFFF_FFFF, 4'hF));
         do_write(wa[i], 32'hFFFF_FFFF, 4'hF, 0, r, lat); e = bq.pop_front();
         total++; if (r !== e) begin bad++; $display("FAIL err_write[%0d] got=%b want=%b", i, r, e); end
      end
      for (int i = 0; i < 5; i++) begin
         rq.push_back(mdl_read(ra[i]));
         do_read(ra[i], g); x = rq.pop_front();
         total++; if (g !== x) begin bad++; $display("FAIL err_read[%0d] got=%h want=%h", i, g, x); end
      end
   endtask

   task automatic test_backpressure;
      logic [1:0] e; logic [33:0] x;
      @(negedge clk);
      bus.awaddr = 32'h0; bus.wdata = 32'h9; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1;
      bq.push_back(mdl_write(32'h0, 32'h9, 4'hF));
      @(negedge clk);
      bus.awvalid = 0; bus.wvalid = 0;
      rq.push_back(mdl_read(32'h0));
      bus.araddr = 32'h0; bus.arvalid = 1;
      @(negedge clk);
      bus.arvalid = 0;
      e = bq.pop_front(); x = rq.pop_front();
      for (int c = 0; c < 5; c++) begin
         bus.awaddr = 32'h4; bus.awvalid = 1; bus.araddr = 32'h4; bus.arvalid = 1;
         @(negedge clk);
         total++; if (bus.bvalid !== 1'b1 || bus.bresp !== e) begin bad++;
            $display("FAIL hold_b cyc=%0d got=%b/%b want=1/%b", c, bus.bvalid, bus.bresp, e); end
         total++; if (bus.rvalid !== 1'b1 || {bus.rresp, bus.rdata} !== x) begin bad++;
            $display("FAIL hold_r cyc=%0d got=%b/%h want=1/%h", c, bus.rvalid, {bus.rresp, bus.rdata}, x); end
         total++; if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin bad++;
            $display("FAIL hold_ready cyc=%0d got=%b%b want=00", c, bus.awready, bus.arready); end
      end
      bus.awvalid = 0; bus.arvalid = 0;
      bus.bready = 1; bus.rready = 1;
      @(negedge clk);
      bus.bready = 0; bus.rready = 0;
      total++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin bad++;
         $display("FAIL hold_release got=%b%b want=00", bus.bvalid, bus.rvalid); end
   endtask

   task automatic test_reset_mid;
      logic [1:0] r, e; int lat; logic [33:0] g, x;
      logic [31:0] ra[3] = '{32'h0, 32'h0C, 32'h10};
      @(negedge clk);
      bus.awaddr = 32'h0; bus.awvalid = 1;
      @(negedge clk);
      bus.awvalid = 0;
      rstn = 1'b0;
      bus.wdata = 32'hF; bus.wstrb = 4'hF; bus.wvalid = 1;
      repeat (2) @(negedge clk);
      bus.wvalid = 0;
      rstn = 1'b1;
      mdl_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rq.push_back(mdl_read(ra[i]));
         do_read(ra[i], g); x = rq.pop_front();
         total++; if (g !== x) begin bad++; $display("FAIL midreset_read[%0d] got=%h want=%h", i, g, x); end
      end
      total++; if (led !== 4'h0) begin bad++; $display("FAIL midreset_led got=%h want=0", led); end
      bq.push_back(mdl_write(32'h0, 32'h3, 4'hF));
      do_write(32'h0, 32'h3, 4'hF, 1, r, lat); e = bq.pop_front();
      total++; if (r !== e) begin bad++; $display("FAIL midreset_write got=%b want=%b", r, e); end
      rq.push_back(mdl_read(32'h0));
      do_read(32'h0, g); x = rq.pop_front();
      total++; if (g !== x) begin bad++; $display("FAIL midreset_readback got=%h want=%h", g, x); end
      total++; if (led !== 4'h3) begin bad++; $display("FAIL midreset_led2 got=%h want=3", led); end
   endtask

   initial begin
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
      mdl_reset();
      test_reset();
      test_write_order();
      test_set_clr();
      test_blink();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axil_led_bank.md
# axil_led_bank

Parametrised AXI4-Lite slave driving a bank of `NUM_LEDS` outputs. It replaces the single fixed 4-bit LED register with a small register file: direct data, atomic set/clear, per-LED blink enable and a programmable blink prescaler. Write address and write data are accepted independently, and the slave applies byte strobes. It sits behind the JTAG-to-AXI bridge as a leaf slave on the AXI4-Lite interconnect.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width; only bits [4:2] are decoded, all other bits are ignored (aliasing).
- `AXI_DATA_WIDTH`, 32, data width; only 32 is supported.
- `NUM_LEDS`, 4, LED count, 1..32.
- `DIV_WIDTH`, 24, blink prescaler width, 1..32.
- `LED_RESET`, 0, reset value of LED_DATA (`NUM_LEDS` bits).
- `s_axi_aclk`  in  1  clock.
- `s_axi_aresetn`  in  1  reset, asynchronous, active-low.
- `s_axi_awaddr/awprot/awvalid`  in  ADDR/3/1;  `s_axi_awready`  out 1.
- `s_axi_wdata/wstrb/wvalid`  in  32/4/1;  `s_axi_wready`  out 1.
- `s_axi_bresp`  out 2;  `s_axi_bvalid`  out 1;  `s_axi_bready`  in 1.
- `s_axi_araddr/arprot/arvalid`  in  ADDR/3/1;  `s_axi_arready`  out 1.
- `s_axi_rdata`  out 32;  `s_axi_rresp`  out 2;  `s_axi_rvalid`  out 1;  `s_axi_rready`  in 1.
- `led_out`  out  NUM_LEDS  LED drive, registered.
- `awprot` and `arprot` are ignored.

## Operation
Register map. Unimplemented bits read 0 and ignore writes.
- 0x00 LED_DATA: RW, bits [NUM_LEDS-1:0].
- 0x04 LED_SET: WO, write 1 sets the corresponding LED_DATA bit; reads 0.
- 0x08 LED_CLR: WO, write 1 clears the corresponding LED_DATA bit; reads 0.
- 0x0C BLINK_EN: RW, bits [NUM_LEDS-1:0]; resets to 0.
- 0x10 BLINK_DIV: RW, bits [DIV_WIDTH-1:0]; resets to all-ones.
- 0x14 INFO: RO. Bit [31] = blink phase, [15:8] = DIV_WIDTH, [7:0] = NUM_LEDS. A write to INFO returns SLVERR and changes no state.
- 0x18–0x1C: unmapped. Read returns SLVERR with rdata 0; write returns SLVERR with no state change.

Write rules:
- Byte strobes: lane k qualifies bits [8k+7:8k] for every writable register, including SET and CLR.
- A write with wstrb = 0 returns OKAY and changes nothing.

Write FSM (W_IDLE, W_RESP):
- In W_IDLE, `awready` = !aw_held and `wready` = !w_held. Each channel is latched on its own handshake, in either order.
- On the edge where both the address and the data are present (held, or handshaking that cycle), the write commits. The FSM enters W_RESP with `bvalid`=1 and both readies at 0.
- In W_RESP, a `bready` handshake clears `bvalid` and both held flags, then returns to W_IDLE.

Read FSM (R_IDLE, R_DATA):
- In R_IDLE, `arready`=1. On handshake, rdata and rresp are decoded from register state at that edge and the FSM enters R_DATA with `rvalid`=1.
- In R_DATA, `arready`=0. `rdata` and `rresp` stay stable until the `rready` handshake, then the FSM returns to R_IDLE.

Blink:
- Prescaler counter `cnt` runs 0..BLINK_DIV. At `cnt` == BLINK_DIV, `cnt` goes to 0 and `phase` toggles.
- Any committed write to BLINK_DIV zeroes `cnt`; `phase` is unaffected.
- `led_out[i]` is registered as LED_DATA[i] & (!BLINK_EN[i] | phase).

## Timing
- Reset values: all readies 0 during reset; `awready`, `wready` and `arready` become 1 the first cycle after reset release. `bvalid`=0, `rvalid`=0, bresp/rresp=00, rdata=0, `led_out`=0, `cnt`=0, `phase`=0.
- Write latency: AW and W handshake together in cycle 0 → register updated and `bvalid`=1 in cycle 1. `led_out` reflects the new value in cycle 2.
- Read latency: AR handshake in cycle 0 → `rvalid`=1 in cycle 1. Sustained throughput is one read every 2 cycles.
- If the read and write paths touch the same register on the same edge, the read returns the pre-write value.
- SET and CLR to the same bit cannot collide, since there is one write at a time.
- BLINK_DIV=0 toggles `phase` every cycle. Period = 2·(BLINK_DIV+1) cycles.
- `cnt` wraps only via the compare; it never overflows.
- Reset asserted mid-transaction aborts it. A write not yet committed has no effect; registers return to their reset values.

## Structure
- Package `led_bank_pkg` holds:
  - register offset localparams;
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the `wr_state_t` and `rd_state_t` enums;
  - the INFO field positions.
- One sub-module, `led_blink_prescaler`: inputs are `div`, `div_load` and enable; output is `phase`.

## Test plan
- Reset, then read 0x14 with NUM_LEDS=4, DIV_WIDTH=24 → rdata 0x0000_1804, OKAY; `led_out`=0.
- AW presented 3 cycles before W, write 0x5 to 0x00 → `bvalid` one cycle after the W handshake, OKAY, `led_out`=0x5. Repeat with W first.
- LED_DATA=0x5: write 0x2 to 0x04, then 0x1 to 0x08 → reads 0x7 then 0x6. Write 0xF to 0x00 with wstrb=0 → unchanged.
- BLINK_DIV=3, BLINK_EN=0x1, LED_DATA=0x1 → `led_out[0]` toggles every 4 cycles (period 8); `led_out[1]` is unaffected.
- Write to 0x14 and 0x1C, read 0x18 → SLVERR each time, rdata 0, no register change. Hold `bready` and `rready` low for 5 cycles → `bvalid`, `rvalid` and rdata stay stable, and no new AW or AR is accepted.
- Assert reset between the AW and W handshakes → LED_DATA keeps its reset value; after release, a fresh write completes normally.
